return_address_stack: RTL and testbench
=======================================

# return_address_stack

Fetch/decode-side companion to the pipelined control decoder: consumes the decoder's `jal`/`jr` indications in ID, pushes return addresses on `jal`, and supplies a predicted `jr` target from the top of stack so fetch can redirect without waiting for the register read. In EX it checks the prediction against the resolved `$ra` value, raises a mispredict redirect, and keeps saturating statistics counters.

## Interface
- `DEPTH`, 8: stack entries; power of two, 2..64.
- `AW`, 32: address width.
- `CNTW`, 16: statistics counter width.

- `CLK` in 1: clock, rising edge.
- `Reset_L` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID-stage instruction valid.
- `id_stall` in 1: ID held this cycle; no stack update.
- `flush` in 1: ID instruction killed this cycle; no stack update.
- `id_jal` in 1: decoder `jal` for the ID instruction.
- `id_jr` in 1: decoder `jr` for the ID instruction.
- `id_pc_plus4` in AW: PC+4 of the ID instruction, which is the return address because there is no delay slot.
- `pred_valid` out 1: top-of-stack prediction available for the `jr` in ID.
- `pred_target` out AW: predicted `jr` target.
- `ex_jr_valid` in 1: a `jr` is resolving in EX.
- `ex_pred_valid` in AW→1: `pred_valid` carried down the pipe with that `jr`.
- `ex_pred_target` in AW: `pred_target` carried down the pipe.
- `ex_actual_target` in AW: forwarded `$rs` value.
- `mispredict` out 1: redirect required.
- `redirect_pc` out AW: correct target.
- `jr_count` out CNTW: resolved `jr` count, saturating.
- `miss_count` out CNTW: mispredict count, saturating.

## Operation
- State consists of `mem[DEPTH]`, top pointer `tp` (log2 DEPTH bits, wraps modulo DEPTH), and `count` (0..DEPTH).
- `go = id_valid & ~id_stall & ~flush`.
- **Push** occurs when `go & id_jal`:
  - `tp' = tp+1` with wrap.
  - `mem[tp'] = id_pc_plus4`.
  - `count' = min(count+1, DEPTH)`.
  - When the stack is full, the push overwrites the oldest entry (circular) and `count` stays at DEPTH.
- **Pop** occurs when `go & id_jr & ~id_jal` and `count != 0`:
  - `tp' = tp-1` with wrap.
  - `count' = count-1`.
- Pop on an empty stack makes no state change.
- If `id_jal` and `id_jr` are both asserted, push wins and no pop occurs.
- **Prediction outputs** are combinational from the current state:
  - `pred_valid = id_valid & id_jr & (count != 0)`.
  - `pred_target = mem[tp]` when `pred_valid`, else 0.
  - Both are unaffected by stall or flush; the consumer ignores them in those cases.
- **Check** is combinational:
  - `mispredict = ex_jr_valid & (~ex_pred_valid | ex_pred_target != ex_actual_target)`.
  - `redirect_pc = ex_actual_target` when `mispredict`, else 0.
- **Counters** update at the clock edge:
  - `jr_count` increments on `ex_jr_valid`.
  - `miss_count` increments on `mispredict`.
  - Both saturate at all-ones.
- No stack repair is performed on mispredict. Wrong-path pushes and pops are prevented only by `flush` gating in ID.

## Timing
- Reset, asynchronous on `Reset_L`=0, clears `tp`=0, `count`=0, all `mem` entries to 0, and both counters to 0.
- Outputs after reset: `pred_valid`=0, `pred_target`=0, `mispredict`=0, `redirect_pc`=0.
- Reset asserted mid-operation discards all entries immediately. The first edge after deassertion behaves as from empty.
- Prediction latency is 0 cycles, i.e. same cycle as `id_jr`. Stack state changes at the next rising edge.
- A `jal` push in cycle N followed by a `jr` in cycle N+1 predicts the value pushed in N. No bypass is needed because push and pop never occur in the same cycle.
- A `jr` held by `id_stall` for k cycles presents the same `pred_target` for all k cycles and pops exactly once, on the first non-stalled edge.
- `flush` together with `id_jal` or `id_jr` gives no update.
- Mispredict latency is 0 cycles from `ex_jr_valid`. The counters reflect the event on the following edge.

## Structure
- Shared header `ras_defs.vh` holds the `DEPTH`/`AW`/`CNTW` defaults and the `jal`/`jr` opcode and function constants, shared with the control decoder.
- One natural sub-module: `ras_regfile`. It is DEPTH×AW with a single write port, an asynchronous read of `mem[tp]`, and async-low clear.
- Pointer, count and counter logic stay in the top module.

## Test plan
- **Reset, then `jr`:** `jr` at 0x0040_0010 with an empty stack → `pred_valid`=0, `pred_target`=0, `count` stays 0. EX resolving that `jr` with actual 0x0040_0100 → `mispredict`=1, `redirect_pc`=0x0040_0100, `miss_count`=1.
- **Nested calls:**
  - Push `jal`s with PC+4 = 0x100, 0x200, 0x300.
  - Three `jr`s predict 0x300, 0x200, 0x100, each with `pred_valid`=1.
  - A fourth `jr` gives `pred_valid`=0.
- **Overflow at DEPTH=8:**
  - Push 0x04..0x24 (9 values) → `count`=8.
  - Eight pops return 0x24 down to 0x08.
  - 0x04 is lost, and the ninth pop gives `pred_valid`=0.
- **Stall and flush:**
  - `jr` stalled 3 cycles with top 0x500 → `pred_target`=0x500 for all 3 cycles and `count` decrements once.
  - `jal` with `flush`=1 → no push.
- **Check path:**
  - `ex_pred_valid`=1, pred 0x700, actual 0x700 → `mispredict`=0 and `jr_count` increments.
  - pred 0x700, actual 0x704 → `mispredict`=1.
- **Saturation and async reset:**
  - With CNTW=4, 20 mispredicts → `miss_count`=15.
  - `Reset_L` pulsed low between edges → counters, `count` and `pred_target` are 0 before the next edge.

Source files
------------

// File: rtl/return_address_stack_pkg.sv
// Shared return-address-stack defaults, decoder opcode constants and the
// per-cycle stack operation select.
package return_address_stack_pkg;

  localparam int RAS_DEPTH = 8;
  localparam int RAS_AW    = 32;
  localparam int RAS_CNTW  = 16;

  // Opcode/function fields the control decoder uses for jal and jr.
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  typedef enum logic [1:0] {
    STK_IDLE,
    STK_PUSH,
    STK_POP
  } stk_op_e;

  // A jal wins over a jr; a pop of an empty stack is dropped.
  function automatic stk_op_e stk_op(input logic go, input logic jal,
                                     input logic jr, input logic nonempty);
    if (go && jal) return STK_PUSH;
    if (go && jr && nonempty) return STK_POP;
    return STK_IDLE;
  endfunction

endpackage

// File: rtl/return_address_stack_ras_regfile.sv
// DEPTH x AW return-address storage: one write port, asynchronous read,
// asynchronous active-low clear.
module ras_regfile #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [AW-1:0] wr_data,
  input  logic [PW-1:0] rd_addr,
  output logic [AW-1:0] rd_data
);

  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/return_address_stack.sv
// Circular return-address stack: pushes on jal, predicts jr targets from the
// top entry, checks them in EX and keeps saturating jr/miss statistics.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int AW    = RAS_AW,
  parameter int CNTW  = RAS_CNTW
) (
  input  logic            CLK,
  input  logic            Reset_L,
  input  logic            id_valid,
  input  logic            id_stall,
  input  logic            flush,
  input  logic            id_jal,
  input  logic            id_jr,
  input  logic [AW-1:0]   id_pc_plus4,
  output logic            pred_valid,
  output logic [AW-1:0]   pred_target,
  input  logic            ex_jr_valid,
  input  logic            ex_pred_valid,
  input  logic [AW-1:0]   ex_pred_target,
  input  logic [AW-1:0]   ex_actual_target,
  output logic            mispredict,
  output logic [AW-1:0]   redirect_pc,
  output logic [CNTW-1:0] jr_count,
  output logic [CNTW-1:0] miss_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]   tp_q, tp_d, tp_inc;
  logic [CW-1:0]   count_q, count_d;
  logic [CNTW-1:0] jr_cnt_q, jr_cnt_d;
  logic [CNTW-1:0] miss_cnt_q, miss_cnt_d;
  logic [AW-1:0]   top_data;
  logic            go;
  logic            wr_en;
  stk_op_e         op;

  assign go     = id_valid & ~id_stall & ~flush;
  assign op     = stk_op(go, id_jal, id_jr, count_q != '0);
  assign tp_inc = tp_q + PW'(1);

  ras_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .PW    (PW)
  ) u_regfile (
    .clk     (CLK),
    .rst_n   (Reset_L),
    .wr_en   (wr_en),
    .wr_addr (tp_inc),
    .wr_data (id_pc_plus4),
    .rd_addr (tp_q),
    .rd_data (top_data)
  );

  // When full, the push lands on the oldest slot and count holds at DEPTH.
  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    wr_en   = 1'b0;
    unique case (op)
      STK_PUSH: begin
        tp_d    = tp_inc;
        wr_en   = 1'b1;
        count_d = (count_q == FULL) ? count_q : count_q + CW'(1);
      end
      STK_POP: begin
        tp_d    = tp_q - PW'(1);
        count_d = count_q - CW'(1);
      end
      default: ;
    endcase
  end

  assign pred_valid  = id_valid & id_jr & (count_q != '0);
  assign pred_target = pred_valid ? top_data : '0;

  assign mispredict  = ex_jr_valid & (~ex_pred_valid | (ex_pred_target != ex_actual_target));
  assign redirect_pc = mispredict ? ex_actual_target : '0;

  always_comb begin
    jr_cnt_d   = jr_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (ex_jr_valid && (jr_cnt_q != '1))  jr_cnt_d   = jr_cnt_q + CNTW'(1);
    if (mispredict && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNTW'(1);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      tp_q       <= '0;
      count_q    <= '0;
      jr_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      tp_q       <= tp_d;
      count_q    <= count_d;
      jr_cnt_q   <= jr_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign jr_count   = jr_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Directed self-checking bench for return_address_stack; a second instance
// with 4-bit counters exercises statistics saturation.
module tb_return_address_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_stall, flush, id_jal, id_jr;
  logic [31:0] id_pc_plus4;
  logic        ex_jr_valid, ex_pred_valid;
  logic [31:0] ex_pred_target, ex_actual_target;

  logic        pred_valid, mispredict;
  logic [31:0] pred_target, redirect_pc;
  logic [15:0] jr_count, miss_count;

  logic        s_pred_valid, s_mispredict;
  logic [31:0] s_pred_target, s_redirect_pc;
  logic [3:0]  s_jr_count, s_miss_count;

  int passes = 0;
  int total  = 0;
  int exp_jr = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  return_address_stack dut (
    .CLK(clk), .Reset_L(rst_n),
    .id_valid(id_valid), .id_stall(id_stall), .flush(flush),
    .id_jal(id_jal), .id_jr(id_jr), .id_pc_plus4(id_pc_plus4),
    .pred_valid(pred_valid), .pred_target(pred_target),
    .ex_jr_valid(ex_jr_valid), .ex_pred_valid(ex_pred_valid),
    .ex_pred_target(ex_pred_target), .ex_actual_target(ex_actual_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .jr_count(jr_count), .miss_count(miss_count)
  );

  return_address_stack #(.DEPTH(8), .AW(32), .CNTW(4)) dut_sat (
    .CLK(clk), .Reset_L(rst_n),
    .id_valid(id_valid), .id_stall(id_stall), .flush(flush),
    .id_jal(id_jal), .id_jr(id_jr), .id_pc_plus4(id_pc_plus4),
    .pred_valid(s_pred_valid), .pred_target(s_pred_target),
    .ex_jr_valid(ex_jr_valid), .ex_pred_valid(ex_pred_valid),
    .ex_pred_target(ex_pred_target), .ex_actual_target(ex_actual_target),
    .mispredict(s_mispredict), .redirect_pc(s_redirect_pc),
    .jr_count(s_jr_count), .miss_count(s_miss_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid = 0; id_stall = 0; flush = 0; id_jal = 0; id_jr = 0; id_pc_plus4 = '0;
  endtask

  task automatic ex_idle();
    ex_jr_valid = 0; ex_pred_valid = 0; ex_pred_target = '0; ex_actual_target = '0;
  endtask

  task automatic push(input logic [31:0] ra);
    id_valid = 1; id_jal = 1; id_jr = 0; id_pc_plus4 = ra;
    step();
    id_idle();
  endtask

  task automatic set_jr(input logic [31:0] pc4);
    id_valid = 1; id_jal = 0; id_jr = 1; id_pc_plus4 = pc4;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; id_idle(); ex_idle();
    #1;
    total++;
    if (pred_valid !== 1'b0 || pred_target !== 32'h0 || mispredict !== 1'b0 || redirect_pc !== 32'h0)
      $display("FAIL reset_outputs: got pv=%0b pt=%h mp=%0b rpc=%h want all 0",
               pred_valid, pred_target, mispredict, redirect_pc);
    else passes++;
    total++;
    if (jr_count !== 16'd0 || miss_count !== 16'd0)
      $display("FAIL reset_counters: got jr=%0d miss=%0d want 0 0", jr_count, miss_count);
    else passes++;
    step();
    rst_n = 1;
    step();
    total++;
    if (pred_valid !== 1'b0 || jr_count !== 16'd0)
      $display("FAIL reset_idle_edge: got pv=%0b jr=%0d want 0 0", pred_valid, jr_count);
    else passes++;
  endtask

  task automatic test_empty_jr();
    set_jr(32'h0040_0014);
    total++;
    if (pred_valid !== 1'b0 || pred_target !== 32'h0)
      $display("FAIL empty_jr_pred: got pv=%0b pt=%h want 0 0", pred_valid, pred_target);
    else passes++;
    step();
    id_idle();
    ex_jr_valid = 1; ex_pred_valid = 0; ex_pred_target = 32'h0; ex_actual_target = 32'h0040_0100;
    #1;
    total++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0040_0100)
      $display("FAIL empty_jr_miss: got mp=%0b rpc=%h want 1 00400100", mispredict, redirect_pc);
    else passes++;
    step();
    ex_idle();
    exp_jr = 1; exp_miss = 1;
    total++;
    if (miss_count !== 16'(exp_miss) || jr_count !== 16'(exp_jr))
      $display("FAIL empty_jr_counts: got jr=%0d miss=%0d want 1 1", jr_count, miss_count);
    else passes++;
    // The empty pop must not have moved count: a fresh push/pop gives exactly one entry.
    push(32'h0000_0ABC);
    set_jr(32'h0);
    step();
    set_jr(32'h0);
    total++;
    if (pred_valid !== 1'b0)
      $display("FAIL empty_jr_count: got pv=%0b want 0", pred_valid);
    else passes++;
    id_idle();
  endtask

  task automatic test_nested();
    logic [31:0] exp_t [3];
    exp_t[0] = 32'h300; exp_t[1] = 32'h200; exp_t[2] = 32'h100;
    push(32'h100); push(32'h200); push(32'h300);
    for (int i = 0; i < 3; i++) begin
      set_jr(32'h1000);
      total++;
      if (pred_valid !== 1'b1 || pred_target !== exp_t[i])
        $display("FAIL nested_pop[%0d]: got pv=%0b pt=%h want 1 %h", i, pred_valid, pred_target, exp_t[i]);
      else passes++;
      step();
    end
    set_jr(32'h1000);
    total++;
    if (pred_valid !== 1'b0 || pred_target !== 32'h0)
      $display("FAIL nested_empty: got pv=%0b pt=%h want 0 0", pred_valid, pred_target);
    else passes++;
    step();
    id_idle();
  endtask

  task automatic test_overflow();
    logic [31:0] want;
    for (int i = 0; i < 9; i++) push(32'h04 + 32'(4 * i));
    for (int i = 0; i < 8; i++) begin
      want = 32'h24 - 32'(4 * i);
      set_jr(32'h2000);
      total++;
      if (pred_valid !== 1'b1 || pred_target !== want)
        $display("FAIL overflow_pop[%0d]: got pv=%0b pt=%h want 1 %h", i, pred_valid, pred_target, want);
      else passes++;
      step();
    end
    set_jr(32'h2000);
    total++;
    if (pred_valid !== 1'b0)
      $display("FAIL overflow_lost: got pv=%0b pt=%h want 0", pred_valid, pred_target);
    else passes++;
    step();
    id_idle();
  endtask

  task automatic test_stall_flush();
    push(32'h400); push(32'h500);
    id_stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_jr(32'h3000);
      id_stall = 1;
      #1;
      total++;
      if (pred_valid !== 1'b1 || pred_target !== 32'h500)
        $display("FAIL stall_hold[%0d]: got pv=%0b pt=%h want 1 500", i, pred_valid, pred_target);
      else passes++;
      step();
    end
    id_stall = 0;
    set_jr(32'h3000);
    total++;
    if (pred_target !== 32'h500)
      $display("FAIL stall_release: got pt=%h want 500", pred_target);
    else passes++;
    step();
    set_jr(32'h3000);
    total++;
    if (pred_valid !== 1'b1 || pred_target !== 32'h400)
      $display("FAIL stall_single_pop: got pv=%0b pt=%h want 1 400", pred_valid, pred_target);
    else passes++;
    step();
    id_idle();
    id_valid = 1; id_jal = 1; flush = 1; id_pc_plus4 = 32'h600;
    step();
    id_idle();
    set_jr(32'h3000);
    total++;
    if (pred_valid !== 1'b0)
      $display("FAIL flush_jal: got pv=%0b pt=%h want 0", pred_valid, pred_target);
    else passes++;
    step();
    push(32'h800);
    set_jr(32'h3000);
    flush = 1;
    step();
    flush = 0;
    set_jr(32'h3000);
    total++;
    if (pred_valid !== 1'b1 || pred_target !== 32'h800)
      $display("FAIL flush_jr: got pv=%0b pt=%h want 1 800", pred_valid, pred_target);
    else passes++;
    step();
    id_idle();
  endtask

  task automatic test_back_to_back();
    push(32'hC00);
    id_valid = 1; id_jal = 1; id_jr = 1; id_pc_plus4 = 32'hD00;
    #1;
    total++;
    if (pred_valid !== 1'b1 || pred_target !== 32'hC00)
      $display("FAIL jal_jr_pred: got pv=%0b pt=%h want 1 c00", pred_valid, pred_target);
    else passes++;
    step();
    set_jr(32'h0);
    total++;
    if (pred_target !== 32'hD00)
      $display("FAIL jal_jr_push_wins: got pt=%h want d00", pred_target);
    else passes++;
    step();
    set_jr(32'h0);
    total++;
    if (pred_target !== 32'hC00)
      $display("FAIL jal_jr_no_pop: got pt=%h want c00", pred_target);
    else passes++;
    step();
    id_idle();
  endtask

  task automatic test_check();
    ex_jr_valid = 1; ex_pred_valid = 1; ex_pred_target = 32'h700; ex_actual_target = 32'h700;
    #1;
    total++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h0)
      $display("FAIL check_hit: got mp=%0b rpc=%h want 0 0", mispredict, redirect_pc);
    else passes++;
    step();
    exp_jr++;
    total++;
    if (jr_count !== 16'(exp_jr) || miss_count !== 16'(exp_miss))
      $display("FAIL check_hit_counts: got jr=%0d miss=%0d want %0d %0d", jr_count, miss_count, exp_jr, exp_miss);
    else passes++;
    ex_actual_target = 32'h704;
    #1;
    total++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h704)
      $display("FAIL check_miss: got mp=%0b rpc=%h want 1 704", mispredict, redirect_pc);
    else passes++;
    step();
    exp_jr++; exp_miss++;
    total++;
    if (jr_count !== 16'(exp_jr) || miss_count !== 16'(exp_miss))
      $display("FAIL check_miss_counts: got jr=%0d miss=%0d want %0d %0d", jr_count, miss_count, exp_jr, exp_miss);
    else passes++;
    ex_pred_valid = 0; ex_actual_target = 32'h700;
    #1;
    total++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h700)
      $display("FAIL check_nopred: got mp=%0b rpc=%h want 1 700", mispredict, redirect_pc);
    else passes++;
    ex_jr_valid = 0;
    #1;
    total++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h0)
      $display("FAIL check_idle: got mp=%0b rpc=%h want 0 0", mispredict, redirect_pc);
    else passes++;
    step();
    total++;
    if (jr_count !== 16'(exp_jr) || miss_count !== 16'(exp_miss))
      $display("FAIL check_idle_counts: got jr=%0d miss=%0d want %0d %0d", jr_count, miss_count, exp_jr, exp_miss);
    else passes++;
    ex_idle();
  endtask

  task automatic test_saturation();
    rst_n = 0;
    #2;
    rst_n = 1;
    ex_jr_valid = 1; ex_pred_valid = 0; ex_actual_target = 32'h1234;
    for (int i = 0; i < 20; i++) step();
    ex_idle();
    #1;
    total++;
    if (s_miss_count !== 4'd15 || s_jr_count !== 4'd15)
      $display("FAIL sat_cntw4: got jr=%0d miss=%0d want 15 15", s_jr_count, s_miss_count);
    else passes++;
    total++;
    if (miss_count !== 16'd20 || jr_count !== 16'd20)
      $display("FAIL sat_cntw16: got jr=%0d miss=%0d want 20 20", jr_count, miss_count);
    else passes++;
  endtask

  task automatic test_async_reset();
    push(32'hA00); push(32'hB00);
    set_jr(32'h0);
    total++;
    if (pred_valid !== 1'b1 || pred_target !== 32'hB00)
      $display("FAIL areset_pre: got pv=%0b pt=%h want 1 b00", pred_valid, pred_target);
    else passes++;
    #2;
    rst_n = 0;
    #1;
    total++;
    if (pred_valid !== 1'b0 || pred_target !== 32'h0 || jr_count !== 16'd0 ||
        miss_count !== 16'd0 || s_miss_count !== 4'd0)
      $display("FAIL areset_immediate: got pv=%0b pt=%h jr=%0d miss=%0d smiss=%0d want 0",
               pred_valid, pred_target, jr_count, miss_count, s_miss_count);
    else passes++;
    #1;
    rst_n = 1;
    #1;
    total++;
    if (pred_valid !== 1'b0)
      $display("FAIL areset_release: got pv=%0b want 0", pred_valid);
    else passes++;
    step();
    id_idle();
    push(32'h900);
    set_jr(32'h0);
    total++;
    if (pred_valid !== 1'b1 || pred_target !== 32'h900)
      $display("FAIL areset_fresh_push: got pv=%0b pt=%h want 1 900", pred_valid, pred_target);
    else passes++;
    step();
    set_jr(32'h0);
    total++;
    if (pred_valid !== 1'b0)
      $display("FAIL areset_old_gone: got pv=%0b pt=%h want 0", pred_valid, pred_target);
    else passes++;
    step();
    id_idle();
  endtask

  initial begin
    test_reset();
    test_empty_jr();
    test_nested();
    test_overflow();
    test_stall_flush();
    test_back_to_back();
    test_check();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
